// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter
// Description : Sequencer/arbiter in front of the single-port data memory.
//               Shares the memory between the pipeline MEM stage (load/store)
//               and a debug/loader port. One access at a time; each access is
//               held on the memory interface for MEM_LAT cycles, then a single
//               DONE cycle returns read data (pipeline) or pulses dbgValid
//               (debug). Ties are broken round-robin against the last owner.
// Ports       : clk, reset              - clock, synchronous active-high reset
//               memReadM/memWriteM      - pipeline load/store request
//               ALUOutM/writeDataM      - pipeline address / store data
//               stallM                  - pipeline freeze (combinational)
//               readDataM               - pipeline load data (held)
//               dbgReq/dbgWe            - debug request / 1=write
//               dbgAddr/dbgWData        - debug address / write data
//               dbgGnt/dbgValid         - debug owns memory / completion pulse
//               dbgRData                - debug read data (held)
//               memActive/memRw         - memory strobe / 1=write
//               memAddr/memWData        - memory address / write data
//               memRData                - memory read data
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memReadM,
  input  logic              memWriteM,
  input  logic [ADDR_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] writeDataM,
  output logic              stallM,
  output logic [DATA_W-1:0] readDataM,
  input  logic              dbgReq,
  input  logic              dbgWe,
  input  logic [ADDR_W-1:0] dbgAddr,
  input  logic [DATA_W-1:0] dbgWData,
  output logic              dbgGnt,
  output logic              dbgValid,
  output logic [DATA_W-1:0] dbgRData,
  output logic              memActive,
  output logic              memRw,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData
);

  localparam int               c_CNT_W    = $clog2(MEM_LAT) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MEM_LAT - 1);
  localparam logic             c_OWN_PIPE = 1'b0;
  localparam logic             c_OWN_DBG  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q,      state_d;
  logic                owner_q,      owner_d;
  logic                last_gnt_q,   last_gnt_d;
  logic [c_CNT_W-1:0]  cnt_q,        cnt_d;
  logic                mem_active_q, mem_active_d;
  logic                mem_rw_q,     mem_rw_d;
  logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;
  logic [DATA_W-1:0]   read_data_q,  read_data_d;
  logic [DATA_W-1:0]   dbg_rdata_q,  dbg_rdata_d;

  logic w_p_req;
  logic w_grant_dbg;

  assign w_p_req = memReadM | memWriteM;

  // Debug wins when it is the only requester, or on a tie when the pipeline
  // held the memory last.
  assign w_grant_dbg = dbgReq & (~w_p_req | (last_gnt_q == c_OWN_PIPE));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_gnt_d   = last_gnt_q;
    cnt_d        = cnt_q;
    mem_active_d = mem_active_q;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    read_data_d  = read_data_q;
    dbg_rdata_d  = dbg_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (w_p_req || dbgReq) begin
          owner_d      = w_grant_dbg;
          // A pipeline request with both read and write set is a write.
          mem_rw_d     = w_grant_dbg ? dbgWe    : memWriteM;
          mem_addr_d   = w_grant_dbg ? dbgAddr  : ALUOutM;
          mem_wdata_d  = w_grant_dbg ? dbgWData : writeDataM;
          mem_active_d = 1'b1;
          cnt_d        = c_CNT_LOAD;
          state_d      = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (cnt_q == '0) begin
          if (!mem_rw_q) begin
            if (owner_q == c_OWN_DBG) begin
              dbg_rdata_d = memRData;
            end else begin
              read_data_d = memRData;
            end
          end
          last_gnt_d   = owner_q;
          // Memory interface returns to its quiet value as the access ends.
          mem_active_d = 1'b0;
          mem_rw_d     = 1'b0;
          mem_addr_d   = '0;
          mem_wdata_d  = '0;
          state_d      = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      // No grant here: the pipeline still presents the request it is being
      // released from, so granting now would issue it twice.
      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= c_OWN_PIPE;
      last_gnt_q   <= c_OWN_DBG;
      cnt_q        <= '0;
      mem_active_q <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      read_data_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_gnt_q   <= last_gnt_d;
      cnt_q        <= cnt_d;
      mem_active_q <= mem_active_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      read_data_q  <= read_data_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign stallM    = w_p_req & ~((state_q == ST_DONE) & (owner_q == c_OWN_PIPE));
  assign readDataM = read_data_q;
  assign dbgGnt    = (state_q == ST_BUSY) & (owner_q == c_OWN_DBG);
  assign dbgValid  = (state_q == ST_DONE) & (owner_q == c_OWN_DBG);
  assign dbgRData  = dbg_rdata_q;
  assign memActive = mem_active_q;
  assign memRw     = mem_rw_q;
  assign memAddr   = mem_addr_q;
  assign memWData  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_arbiter
// Description : Self-checking bench for data_mem_arbiter. A timestamp-based
//               transaction model predicts every output each cycle; directed
//               scenarios add literal expectations, then randomized pipeline
//               and debug traffic (with occasional resets) follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int MEM_LAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              memReadM, memWriteM;
  logic [ADDR_W-1:0] ALUOutM;
  logic [DATA_W-1:0] writeDataM;
  logic              stallM;
  logic [DATA_W-1:0] readDataM;
  logic              dbgReq, dbgWe;
  logic [ADDR_W-1:0] dbgAddr;
  logic [DATA_W-1:0] dbgWData;
  logic              dbgGnt, dbgValid;
  logic [DATA_W-1:0] dbgRData;
  logic              memActive, memRw;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWData;
  logic [DATA_W-1:0] memRData;

  data_mem_arbiter #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memReadM  (memReadM),
    .memWriteM (memWriteM),
    .ALUOutM   (ALUOutM),
    .writeDataM(writeDataM),
    .stallM    (stallM),
    .readDataM (readDataM),
    .dbgReq    (dbgReq),
    .dbgWe     (dbgWe),
    .dbgAddr   (dbgAddr),
    .dbgWData  (dbgWData),
    .dbgGnt    (dbgGnt),
    .dbgValid  (dbgValid),
    .dbgRData  (dbgRData),
    .memActive (memActive),
    .memRw     (memRw),
    .memAddr   (memAddr),
    .memWData  (memWData),
    .memRData  (memRData)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Transaction model: an access granted at the end of cycle S occupies the
  // memory in cycles S+1..S+MEM_LAT and completes in cycle S+MEM_LAT+1.
  // --------------------------------------------------------------------------
  bit               m_valid    = 1'b0;
  bit               m_busy     = 1'b0;
  int               m_start    = 0;
  bit               m_dbg      = 1'b0;
  bit               m_we       = 1'b0;
  bit               m_last_dbg = 1'b1;
  logic [ADDR_W-1:0] m_addr    = '0;
  logic [DATA_W-1:0] m_wdata   = '0;
  logic [DATA_W-1:0] m_rd_pipe = '0;
  logic [DATA_W-1:0] m_rd_dbg  = '0;
  bit               m_prev_stall = 1'b0;
  bit               m_prev_val   = 1'b0;

  always @(posedge clk) begin
    bit p_req;
    int ph;
    p_req = memReadM | memWriteM;
    if (reset) begin
      m_valid    = 1'b1;
      m_busy     = 1'b0;
      m_last_dbg = 1'b1;
      m_rd_pipe  = '0;
      m_rd_dbg   = '0;
    end else if (m_valid) begin
      if (m_busy) begin
        ph = cyc - m_start;
        if (ph == MEM_LAT) begin
          if (!m_we) begin
            if (m_dbg) m_rd_dbg = memRData;
            else       m_rd_pipe = memRData;
          end
          m_last_dbg = m_dbg;
        end
        if (ph == MEM_LAT + 1) m_busy = 1'b0;
      end else if (p_req || dbgReq) begin
        m_busy  = 1'b1;
        m_start = cyc;
        m_dbg   = dbgReq && (!p_req || !m_last_dbg);
        m_we    = m_dbg ? dbgWe : memWriteM;
        m_addr  = m_dbg ? dbgAddr : ALUOutM;
        m_wdata = m_dbg ? dbgWData : writeDataM;
      end
    end
    cyc = cyc + 1;
  end

  // Compare process: every output, every cycle once reset has been seen.
  always @(negedge clk) begin
    int ph;
    bit in_mem, in_done, e_stall;
    if (m_valid) begin
      ph      = cyc - m_start;
      in_mem  = m_busy && (ph >= 1) && (ph <= MEM_LAT);
      in_done = m_busy && (ph == MEM_LAT + 1);
      e_stall = (memReadM | memWriteM) && !(in_done && !m_dbg);
      chk("memActive", memActive, in_mem);
      chk("memRw",     memRw,     in_mem ? m_we : 1'b0);
      chk("memAddr",   memAddr,   in_mem ? m_addr : '0);
      chk("memWData",  memWData,  in_mem ? m_wdata : '0);
      chk("dbgGnt",    dbgGnt,    in_mem && m_dbg);
      chk("dbgValid",  dbgValid,  in_done && m_dbg);
      chk("stallM",    stallM,    e_stall);
      chk("readDataM", readDataM, m_rd_pipe);
      chk("dbgRData",  dbgRData,  m_rd_dbg);
      m_prev_stall = e_stall;
      m_prev_val   = in_done && m_dbg;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance to the next cycle, then let combinational outputs settle.
  task automatic next();
    tick();
    #2;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; memReadM = 1'b0; memWriteM = 1'b0; ALUOutM = '0; writeDataM = '0;
    dbgReq = 1'b0; dbgWe = 1'b0; dbgAddr = '0; dbgWData = '0; memRData = '0;
    tick(); tick();
    reset = 1'b0;
    #2;
    chk("rst memActive", memActive, 1'b0);
    chk("rst readDataM", readDataM, 32'h0);
    tick();

    // Load 0x10 -> 0xDEADBEEF
    memReadM = 1'b1; ALUOutM = 32'h10; memRData = 32'hDEADBEEF;
    #2 chk("t1 stall c0", stallM, 1'b1);
    next(); chk("t1 act c1", memActive, 1'b1); chk("t1 rw c1", memRw, 1'b0);
            chk("t1 addr c1", memAddr, 32'h10); chk("t1 stall c1", stallM, 1'b1);
    next(); chk("t1 act c2", memActive, 1'b1); chk("t1 stall c2", stallM, 1'b1);
    next(); chk("t1 stall c3", stallM, 1'b0); chk("t1 rdata c3", readDataM, 32'hDEADBEEF);
    tick(); memReadM = 1'b0; memRData = '0;

    // Store 0x20 <- 0x12345678
    memWriteM = 1'b1; ALUOutM = 32'h20; writeDataM = 32'h12345678; memRData = 32'hFFFFFFFF;
    next(); chk("t2 rw c1", memRw, 1'b1); chk("t2 addr c1", memAddr, 32'h20);
            chk("t2 wdata c1", memWData, 32'h12345678);
    next(); chk("t2 rw c2", memRw, 1'b1);
    next(); chk("t2 stall c3", stallM, 1'b0); chk("t2 rdata held", readDataM, 32'hDEADBEEF);
    tick(); memWriteM = 1'b0;

    // Tie after reset: pipeline first, then a second tie goes to debug
    reset = 1'b1; tick(); reset = 1'b0;
    memReadM = 1'b1; ALUOutM = 32'h30; dbgReq = 1'b1; dbgWe = 1'b0; dbgAddr = 32'h50;
    memRData = 32'h11111111;
    next(); chk("t3 gnt c1", dbgGnt, 1'b0); chk("t3 addr c1", memAddr, 32'h30);
    next();
    next(); chk("t3 stall c3", stallM, 1'b0); chk("t3 rdata c3", readDataM, 32'h11111111);
    tick(); memReadM = 1'b0; memWriteM = 1'b1; ALUOutM = 32'h44; writeDataM = 32'h55;
    memRData = 32'h22222222;
    next(); chk("t3 gnt c5", dbgGnt, 1'b1); chk("t3 addr c5", memAddr, 32'h50);
            chk("t3 stall c5", stallM, 1'b1);
    next();
    next(); chk("t3 valid c7", dbgValid, 1'b1); chk("t3 drdata c7", dbgRData, 32'h22222222);
            chk("t3 stall c7", stallM, 1'b1);
    tick(); dbgReq = 1'b0;
    next(); chk("t3 addr c9", memAddr, 32'h44); chk("t3 rw c9", memRw, 1'b1);
    next();
    next(); chk("t3 stall c11", stallM, 1'b0);
    tick(); memWriteM = 1'b0;

    // Debug read 0x40, pipeline idle
    dbgReq = 1'b1; dbgWe = 1'b0; dbgAddr = 32'h40; memRData = 32'hA5A5A5A5;
    next(); chk("t4 gnt c1", dbgGnt, 1'b1);
    next(); chk("t4 gnt c2", dbgGnt, 1'b1);
    next(); chk("t4 valid c3", dbgValid, 1'b1); chk("t4 drdata c3", dbgRData, 32'hA5A5A5A5);
    tick(); dbgReq = 1'b0;

    // Reset in the first BUSY cycle of a debug access
    dbgReq = 1'b1; dbgAddr = 32'h60;
    next(); chk("t5 act c1", memActive, 1'b1);
    reset = 1'b1;
    tick(); reset = 1'b0; dbgReq = 1'b0;
    #2; chk("t5 act c2", memActive, 1'b0); chk("t5 rdata c2", readDataM, 32'h0);
    next(); chk("t5 valid c3", dbgValid, 1'b0);
    next(); chk("t5 valid c4", dbgValid, 1'b0);
    tick();

    // Read and write together is a write
    memReadM = 1'b1; memWriteM = 1'b1; ALUOutM = 32'h8; writeDataM = 32'hCAFEF00D;
    memRData = 32'h99999999;
    next(); chk("t6 rw c1", memRw, 1'b1); chk("t6 addr c1", memAddr, 32'h8);
    next(); chk("t6 rw c2", memRw, 1'b1);
    next(); chk("t6 stall c3", stallM, 1'b0); chk("t6 rdata held", readDataM, 32'h0);
    tick(); memReadM = 1'b0; memWriteM = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tick();
      reset    = ($urandom_range(0, 299) == 0);
      memRData = $urandom;
      if (!((memReadM | memWriteM) && m_prev_stall)) begin
        case ($urandom_range(0, 7))
          0, 1, 2: begin memReadM = 1'b0; memWriteM = 1'b0; end
          3, 4:    begin memReadM = 1'b1; memWriteM = 1'b0; end
          5, 6:    begin memReadM = 1'b0; memWriteM = 1'b1; end
          default: begin memReadM = 1'b1; memWriteM = 1'b1; end
        endcase
        ALUOutM    = $urandom;
        writeDataM = $urandom;
      end
      if (m_prev_val) begin
        dbgReq = 1'b0;
      end else if (dbgReq) begin
        // Dropping the request is legal once its access is on the memory.
        if (m_busy && m_dbg && (cyc - m_start >= 1) && (cyc - m_start <= MEM_LAT)
            && ($urandom_range(0, 7) == 0))
          dbgReq = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        dbgReq   = 1'b1;
        dbgWe    = $urandom_range(0, 1);
        dbgAddr  = $urandom;
        dbgWData = $urandom;
      end
    end
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
